// File: rtl/id_stage.sv
// RV32I decode of OP/OP-IMM/LUI/AUIPC into ALU operand form, held in one output register.
// Latency 1, throughput 1/cycle; if_ready = !ex_valid || ex_ready, and the entry holds while execute stalls.
module id_stage #(
    parameter int ARCH_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [31:0]         if_instr,
    input  logic [ARCH_LEN-1:0] if_pc,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [ARCH_LEN-1:0] rs1_data,
    input  logic [ARCH_LEN-1:0] rs2_data,
    input  logic                flush,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ARCH_LEN-1:0] ex_operand1,
    output logic [ARCH_LEN-1:0] ex_operand2,
    output logic [2:0]          ex_alu_op3,
    output logic [6:0]          ex_alu_op7,
    output logic [4:0]          ex_rd,
    output logic                ex_rd_we,
    output logic                ex_illegal,
    output logic [ARCH_LEN-1:0] ex_pc
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [ARCH_LEN-1:0] op1;
        logic [ARCH_LEN-1:0] op2;
        logic [ARCH_LEN-1:0] pc;
        logic [2:0]          op3;
        logic [6:0]          op7;
        logic [4:0]          rd;
        logic                rd_we;
        logic                illegal;
    } ex_entry_t;

    ex_entry_t  dec;
    ex_entry_t  entry;
    logic       valid;
    logic       legal;
    logic       load;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    assign if_ready = !valid || ex_ready;
    assign load     = if_valid && if_ready && !flush;

    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.pc  = if_pc;
        dec.rd  = if_instr[11:7];
        case (opcode)
            OPC_OP: begin
                legal   = (funct7 == 7'd0) ||
                          (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
                dec.op1 = rs1_data;
                dec.op3 = funct3;
                dec.op7 = funct7;
                // The ALU only adds on func3 000, so SUB is folded into a negated operand.
                if (funct3 == 3'b000 && funct7 == F7_ALT)
                    dec.op2 = (~rs2_data) + ARCH_LEN'(1);
                else
                    dec.op2 = rs2_data;
            end
            OPC_IMM: begin
                dec.op1 = rs1_data;
                dec.op3 = funct3;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.op2 = {{(ARCH_LEN-5){1'b0}}, if_instr[24:20]};
                    dec.op7 = funct7;
                    legal   = (funct7 == 7'd0) || (funct3 == 3'b101 && funct7 == F7_ALT);
                end else begin
                    dec.op2 = {{(ARCH_LEN-12){if_instr[31]}}, if_instr[31:20]};
                    legal   = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.op2 = {if_instr[31:12], {(ARCH_LEN-20){1'b0}}};
                legal   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op1 = if_pc;
                dec.op2 = {if_instr[31:12], {(ARCH_LEN-20){1'b0}}};
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op1 = '0;
            dec.op2 = '0;
            dec.op3 = '0;
            dec.op7 = '0;
        end
        dec.illegal = !legal;
        dec.rd_we   = legal && (dec.rd != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            entry <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (ex_ready)
                valid <= 1'b0;
            if (load)
                entry <= dec;
        end
    end

    assign ex_valid    = valid;
    assign ex_operand1 = entry.op1;
    assign ex_operand2 = entry.op2;
    assign ex_alu_op3  = entry.op3;
    assign ex_alu_op7  = entry.op7;
    assign ex_rd       = entry.rd;
    assign ex_rd_we    = entry.rd_we;
    assign ex_illegal  = entry.illegal;
    assign ex_pc       = entry.pc;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a queue-based reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, flush, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd;
    logic [31:0] ex_operand1, ex_operand2, ex_pc;
    logic [2:0]  ex_alu_op3;
    logic [6:0]  ex_alu_op7;
    logic        ex_rd_we, ex_illegal;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [2:0]  op3;
        logic [6:0]  op7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } ent_t;

    ent_t q[$];

    id_stage #(.ARCH_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2),
        .ex_alu_op3(ex_alu_op3), .ex_alu_op7(ex_alu_op7), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    // Reference decode written from the instruction-set rules with plain arithmetic.
    function automatic ent_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc);
        ent_t        e;
        bit          ok;
        int          simm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        simm = int'(ins[31:20]);
        if (simm >= 2048) simm = simm - 4096;
        e    = '0;
        e.pc = pc;
        e.rd = ins[11:7];
        ok   = 1'b0;
        if (opc == 7'h33) begin
            ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.op1 = a;
            e.op2 = (f3 == 3'd0 && f7 == 7'h20) ? 32'd0 - b : b;
            e.op3 = f3;
            e.op7 = f7;
        end else if (opc == 7'h13) begin
            e.op1 = a;
            e.op3 = f3;
            if (f3 == 3'd1) begin
                ok    = (f7 == 7'h00);
                e.op2 = 32'(ins[24:20]);
                e.op7 = f7;
            end else if (f3 == 3'd5) begin
                ok    = (f7 == 7'h00) || (f7 == 7'h20);
                e.op2 = 32'(ins[24:20]);
                e.op7 = f7;
            end else begin
                ok    = 1'b1;
                e.op2 = 32'(simm);
            end
        end else if (opc == 7'h37) begin
            ok    = 1'b1;
            e.op2 = 32'(ins[31:12]) * 32'd4096;
        end else if (opc == 7'h17) begin
            ok    = 1'b1;
            e.op1 = pc;
            e.op2 = 32'(ins[31:12]) * 32'd4096;
        end
        if (!ok) begin
            e.op1 = 32'd0;
            e.op2 = 32'd0;
            e.op3 = 3'd0;
            e.op7 = 7'd0;
        end
        e.ill = !ok;
        e.we  = ok && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input ent_t e);
        chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
        chk({tag, ".op1"},   ex_operand1, e.op1);
        chk({tag, ".op2"},   ex_operand2, e.op2);
        chk({tag, ".op3"},   32'(ex_alu_op3), 32'(e.op3));
        chk({tag, ".op7"},   32'(ex_alu_op7), 32'(e.op7));
        chk({tag, ".rd"},    32'(ex_rd), 32'(e.rd));
        chk({tag, ".we"},    32'(ex_rd_we), 32'(e.we));
        chk({tag, ".ill"},   32'(ex_illegal), 32'(e.ill));
        chk({tag, ".pc"},    ex_pc, e.pc);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        rs1_data = a;
        rs2_data = b;
        if_pc    = pc;
    endtask

    // Issue one instruction with execute ready and check the registered result.
    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc);
        drive(ins, a, b, pc);
        #1;
        chk({tag, ".rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
        chk({tag, ".rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
        chk({tag, ".if_ready"}, 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk_entry(tag, model(ins, a, b, pc));
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 4);
        case (sel)
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            default: ;
        endcase
        if (sel < 2 && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        logic rdy;
        ent_t first;
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        if_instr = 32'd0; if_pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;

        // Reset state
        #2;
        chk("rst.valid", 32'(ex_valid), 32'd0);
        chk("rst.if_ready", 32'(if_ready), 32'd1);
        chk("rst.op1", ex_operand1, 32'd0);
        chk("rst.op2", ex_operand2, 32'd0);
        chk("rst.pc", ex_pc, 32'd0);
        chk("rst.misc", {16'd0, ex_alu_op3, ex_alu_op7, ex_rd, ex_rd_we}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.valid", 32'(ex_valid), 32'd0);

        // Directed decode vectors
        issue("add", 32'h002081B3, 32'd5, 32'd7, 32'h40);
        chk("add.op2_const", ex_operand2, 32'd7);
        chk("add.rd_const", 32'(ex_rd), 32'd3);
        issue("sub", 32'h402081B3, 32'd10, 32'd3, 32'h44);
        chk("sub.op2_const", ex_operand2, 32'hFFFFFFFD);
        chk("sub.op7_const", 32'(ex_alu_op7), 32'h20);
        issue("addi", 32'hFFF00093, 32'd9, 32'd0, 32'h48);
        chk("addi.op2_const", ex_operand2, 32'hFFFFFFFF);
        issue("srai", 32'h40435293, 32'h80000000, 32'd0, 32'h4C);
        chk("srai.op2_const", ex_operand2, 32'd4);
        chk("srai.op7_const", 32'(ex_alu_op7), 32'h20);
        issue("lui", 32'h123453B7, 32'd77, 32'd0, 32'h50);
        chk("lui.op2_const", ex_operand2, 32'h12345000);
        issue("auipc", 32'h00001517, 32'd0, 32'd0, 32'h100);
        chk("auipc.op1_const", ex_operand1, 32'h100);
        chk("auipc.op2_const", ex_operand2, 32'h1000);
        issue("load_op", 32'h00000003, 32'd1, 32'd2, 32'h54);
        chk("load_op.ill_const", 32'(ex_illegal), 32'd1);
        issue("add_f7_1", 32'h022081B3, 32'd1, 32'd2, 32'h58);
        chk("add_f7_1.ill_const", 32'(ex_illegal), 32'd1);
        issue("nop", 32'h00000013, 32'd0, 32'd0, 32'h5C);
        chk("nop.we_const", 32'(ex_rd_we), 32'd0);
        chk("nop.ill_const", 32'(ex_illegal), 32'd0);
        @(posedge clk); #1;
        chk("drain.valid", 32'(ex_valid), 32'd0);

        // Backpressure: second ADD held off for two cycles, then delivered once
        ex_ready = 1'b0;
        drive(32'h002081B3, 32'd1, 32'd2, 32'h200);
        @(posedge clk); #1;
        first = model(32'h002081B3, 32'd1, 32'd2, 32'h200);
        drive(32'h00208233, 32'd20, 32'd30, 32'h204);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp.if_ready", 32'(if_ready), 32'd0);
            chk_entry("bp.hold", first);
            @(posedge clk); #1;
        end
        chk_entry("bp.hold_end", first);
        ex_ready = 1'b1;
        #1;
        chk("bp.if_ready_up", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk_entry("bp.second", model(32'h00208233, 32'd20, 32'd30, 32'h204));
        @(posedge clk); #1;
        chk("bp.no_dup", 32'(ex_valid), 32'd0);

        // Flush while stalled: held entry and offered ADD both vanish
        ex_ready = 1'b0;
        drive(32'h002081B3, 32'd3, 32'd4, 32'h300);
        @(posedge clk); #1;
        chk("fl.loaded", 32'(ex_valid), 32'd1);
        drive(32'h00208233, 32'd5, 32'd6, 32'h304);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        chk("fl.valid", 32'(ex_valid), 32'd0);
        @(posedge clk); #1;
        chk("fl.never", 32'(ex_valid), 32'd0);

        // Randomized traffic against the queue model
        q.delete();
        for (int n = 0; n < 400; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_instr = gen_instr();
            rs1_data = $urandom;
            rs2_data = $urandom;
            if_pc    = $urandom & 32'hFFFFFFFC;
            #1;
            rdy = (q.size() == 0) || ex_ready;
            chk("rnd.if_ready", 32'(if_ready), 32'(rdy));
            chk("rnd.rs1_addr", 32'(rs1_addr), 32'(if_instr[19:15]));
            chk("rnd.rs2_addr", 32'(rs2_addr), 32'(if_instr[24:20]));
            if (flush) begin
                q.delete();
            end else begin
                if (ex_ready && q.size() > 0) void'(q.pop_front());
                if (if_valid && rdy) q.push_back(model(if_instr, rs1_data, rs2_data, if_pc));
            end
            @(posedge clk); #1;
            chk("rnd.valid", 32'(ex_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk_entry("rnd", q[0]);
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a stall
        ex_ready = 1'b0;
        drive(32'h002081B3, 32'd8, 32'd9, 32'h400);
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk("ar.loaded", 32'(ex_valid), 32'd1);
        @(posedge clk); #1;
        chk("ar.held", 32'(ex_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(ex_valid), 32'd0);
        chk("ar.if_ready", 32'(if_ready), 32'd1);
        chk("ar.op1", ex_operand1, 32'd0);
        chk("ar.pc", ex_pc, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
